// File: rtl/rf_wb_queue.sv
// rf_wb_queue: register-file writeback queue.
// Collects writeback requests from the load unit and the ALU into a small
// circular FIFO and drains one entry per unstalled cycle into the register
// file write port.
// Optional feature: define RF_WB_BYPASS_EN to enable the operand bypass
// search over queued entries; otherwise the bypass outputs are tied to 0.

module rf_wb_queue #(
   parameter int addr_width_p = 6,
   parameter int depth_p      = 4
) (
   input  logic                       clk,
   input  logic                       reset_i,

   input  logic                       mem_v_i,
   input  logic [addr_width_p-1:0]    mem_addr_i,
   input  logic [31:0]                mem_data_i,
   output logic                       mem_ready_o,

   input  logic                       alu_v_i,
   input  logic [addr_width_p-1:0]    alu_addr_i,
   input  logic [31:0]                alu_data_i,
   output logic                       alu_ready_o,

   input  logic                       stall_i,

   output logic                       wen_o,
   output logic [addr_width_p-1:0]    rd_addr_o,
   output logic [31:0]                write_data_o,

   input  logic [addr_width_p-1:0]    rs_addr_i,
   output logic                       byp_hit_o,
   output logic [31:0]                byp_data_o,

   output logic [$clog2(depth_p):0]   count_o
);

   localparam int ptr_width_lp = $clog2(depth_p);
   localparam int cnt_width_lp = ptr_width_lp + 1;
   localparam logic [cnt_width_lp-1:0] depth_lp = cnt_width_lp'(depth_p);

   logic [addr_width_p-1:0]  addr_mem [depth_p];
   logic [31:0]              data_mem [depth_p];

   logic [ptr_width_lp-1:0]  head_r;
   logic [ptr_width_lp-1:0]  tail_r;
   logic [cnt_width_lp-1:0]  count_r;

   logic                     full;
   logic                     empty;
   logic                     mem_acc;
   logic                     alu_acc;
   logic                     enq;
   logic                     deq;
   logic [addr_width_p-1:0]  enq_addr;
   logic [31:0]              enq_data;

   // The queue counts as empty while reset is held so that nothing reaches the
   // register file during a reset cycle, even if stale entries are still held.
   assign full  = (count_r == depth_lp);
   assign empty = (count_r == '0) | reset_i;

   // Readiness depends only on the registered occupancy, so a full queue
   // refuses new work even when it is draining in the same cycle.
   assign mem_ready_o = !full;
   assign alu_ready_o = !full & !mem_v_i;

   // The load unit has priority; the ALU ready already excludes it, so at
   // most one of the two accepts can be high.
   assign mem_acc  = mem_v_i & mem_ready_o;
   assign alu_acc  = alu_v_i & alu_ready_o;
   assign enq      = (mem_acc | alu_acc) & !reset_i;
   assign enq_addr = mem_acc ? mem_addr_i : alu_addr_i;
   assign enq_data = mem_acc ? mem_data_i : alu_data_i;

   assign wen_o        = !empty & !stall_i;
   assign deq          = wen_o;
   assign rd_addr_o    = empty ? '0 : addr_mem[head_r];
   assign write_data_o = empty ? '0 : data_mem[head_r];
   assign count_o      = reset_i ? '0 : count_r;

   // Pointer and occupancy bookkeeping; pointers wrap naturally because the
   // depth is a power of two.
   always_ff @(posedge clk) begin
      if (reset_i) begin
         head_r  <= '0;
         tail_r  <= '0;
         count_r <= '0;
      end else begin
         if (enq) begin
            tail_r <= tail_r + 1'b1;
         end
         if (deq) begin
            head_r <= head_r + 1'b1;
         end
         case ({enq, deq})
            2'b10:   count_r <= count_r + 1'b1;
            2'b01:   count_r <= count_r - 1'b1;
            default: count_r <= count_r;
         endcase
      end
   end

   // Entry storage needs no reset: only slots covered by the count are ever read.
   always_ff @(posedge clk) begin
      if (enq) begin
         addr_mem[tail_r] <= enq_addr;
         data_mem[tail_r] <= enq_data;
      end
   end

`ifdef RF_WB_BYPASS_EN
   logic [ptr_width_lp-1:0] byp_idx;

   // Walk the live entries oldest to newest so that the newest match wins.
   always_comb begin
      byp_hit_o  = 1'b0;
      byp_data_o = '0;
      byp_idx    = head_r;
      for (int i = 0; i < depth_p; i++) begin
         byp_idx = head_r + ptr_width_lp'(i);
         if (!reset_i && (cnt_width_lp'(i) < count_r) &&
             (addr_mem[byp_idx] == rs_addr_i)) begin
            byp_hit_o  = 1'b1;
            byp_data_o = data_mem[byp_idx];
         end
      end
   end
`else
   logic unused_rs_addr;

   assign unused_rs_addr = ^rs_addr_i;
   assign byp_hit_o      = 1'b0;
   assign byp_data_o     = '0;
`endif

endmodule

// File: tb/tb_rf_wb_queue.sv
// tb_rf_wb_queue: directed bench for rf_wb_queue with a scoreboard queue of
// expected register-file writes. Build with RF_WB_BYPASS_EN defined to also
// exercise the bypass search; otherwise the bypass outputs must stay at 0.

module tb_rf_wb_queue;

   localparam int AW    = 6;
   localparam int DEPTH = 4;

   typedef struct {
      logic [AW-1:0] addr;
      logic [31:0]   data;
   } entry_t;

   logic                    clk;
   logic                    reset_i;
   logic                    mem_v_i;
   logic [AW-1:0]           mem_addr_i;
   logic [31:0]             mem_data_i;
   logic                    mem_ready_o;
   logic                    alu_v_i;
   logic [AW-1:0]           alu_addr_i;
   logic [31:0]             alu_data_i;
   logic                    alu_ready_o;
   logic                    stall_i;
   logic                    wen_o;
   logic [AW-1:0]           rd_addr_o;
   logic [31:0]             write_data_o;
   logic [AW-1:0]           rs_addr_i;
   logic                    byp_hit_o;
   logic [31:0]             byp_data_o;
   logic [$clog2(DEPTH):0]  count_o;

   entry_t sb[$];
   int     errors;
   int     checks;
   int     maxCnt;
   bit     trackMax;

   rf_wb_queue #(
      .addr_width_p (AW),
      .depth_p      (DEPTH)
   ) dut (
      .clk          (clk),
      .reset_i      (reset_i),
      .mem_v_i      (mem_v_i),
      .mem_addr_i   (mem_addr_i),
      .mem_data_i   (mem_data_i),
      .mem_ready_o  (mem_ready_o),
      .alu_v_i      (alu_v_i),
      .alu_addr_i   (alu_addr_i),
      .alu_data_i   (alu_data_i),
      .alu_ready_o  (alu_ready_o),
      .stall_i      (stall_i),
      .wen_o        (wen_o),
      .rd_addr_o    (rd_addr_o),
      .write_data_o (write_data_o),
      .rs_addr_i    (rs_addr_i),
      .byp_hit_o    (byp_hit_o),
      .byp_data_o   (byp_data_o),
      .count_o      (count_o)
   );

   // Free-running clock, first rising edge at 5.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case the sequence never completes.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
         $error("[TB] check %s did not hold", tag);
      end
   endtask

   task automatic applyStimulus(input logic mv, input logic [AW-1:0] ma, input logic [31:0] md,
                                input logic av, input logic [AW-1:0] aa, input logic [31:0] ad,
                                input logic st);
      mem_v_i    = mv;
      mem_addr_i = ma;
      mem_data_i = md;
      alu_v_i    = av;
      alu_addr_i = aa;
      alu_data_i = ad;
      stall_i    = st;
   endtask

   // Compare every output against the scoreboard model, then advance the
   // model by what the current inputs should do at the coming edge.
   task automatic checkOutput();
      logic   expMemReady;
      logic   expAluReady;
      logic   expWen;
      logic   expHit;
      logic [31:0] expByp;
      entry_t head;
      entry_t e;
      if (reset_i) begin
         checkVal("rst_wen",   32'(wen_o),        32'd0);
         checkVal("rst_rd",    32'(rd_addr_o),    32'd0);
         checkVal("rst_data",  write_data_o,      32'd0);
         checkVal("rst_count", 32'(count_o),      32'd0);
         checkVal("rst_hit",   32'(byp_hit_o),    32'd0);
         checkVal("rst_byp",   byp_data_o,        32'd0);
         sb.delete();
         return;
      end
      expMemReady = (sb.size() < DEPTH);
      expAluReady = expMemReady && !mem_v_i;
      expWen      = (sb.size() != 0) && !stall_i;
      checkVal("mem_ready", 32'(mem_ready_o), 32'(expMemReady));
      checkVal("alu_ready", 32'(alu_ready_o), 32'(expAluReady));
      checkVal("count",     32'(count_o),     32'(sb.size()));
      checkVal("wen",       32'(wen_o),       32'(expWen));
      head.addr = '0;
      head.data = '0;
      if (sb.size() != 0) begin
         head = sb[0];
      end
      checkVal("rd_addr",    32'(rd_addr_o), 32'(head.addr));
      checkVal("write_data", write_data_o,   head.data);
      expHit = 1'b0;
      expByp = '0;
`ifdef RF_WB_BYPASS_EN
      foreach (sb[i]) begin
         if (sb[i].addr == rs_addr_i) begin
            expHit = 1'b1;
            expByp = sb[i].data;
         end
      end
`endif
      checkVal("byp_hit",  32'(byp_hit_o), 32'(expHit));
      checkVal("byp_data", byp_data_o,     expByp);
      if (trackMax && (int'(count_o) > maxCnt)) begin
         maxCnt = int'(count_o);
      end
      if (expWen) begin
         void'(sb.pop_front());
      end
      if (expMemReady && mem_v_i) begin
         e.addr = mem_addr_i;
         e.data = mem_data_i;
         sb.push_back(e);
      end else if (expAluReady && alu_v_i) begin
         e.addr = alu_addr_i;
         e.data = alu_data_i;
         sb.push_back(e);
      end
   endtask

   task automatic cycle();
      @(negedge clk);
      checkOutput();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input logic st);
      applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, st);
   endtask

   task automatic drain(input string tag);
      idle(1'b0);
      for (int n = 0; n < 12 && sb.size() != 0; n++) begin
         cycle();
      end
      @(negedge clk);
      checkVal(tag, 32'(count_o), 32'd0);
      @(posedge clk);
      #1;
   endtask

   // Directed sequence of scenarios.
   initial begin
      errors   = 0;
      checks   = 0;
      maxCnt   = 0;
      trackMax = 1'b0;
      reset_i  = 1'b1;
      rs_addr_i = '0;
      idle(1'b0);
      cycle();
      cycle();
      reset_i = 1'b0;
      cycle();

      $display("[TB] single load writeback");
      applyStimulus(1'b1, 6'd5, 32'hDEADBEEF, 1'b0, '0, '0, 1'b0);
      cycle();
      idle(1'b0);
      cycle();
      cycle();

      $display("[TB] load and ALU collide");
      applyStimulus(1'b1, 6'd3, 32'hA3A3_0003, 1'b1, 6'd4, 32'hA4A4_0004, 1'b0);
      cycle();
      applyStimulus(1'b0, '0, '0, 1'b1, 6'd4, 32'hA4A4_0004, 1'b0);
      cycle();
      idle(1'b0);
      cycle();
      cycle();

      $display("[TB] fill under stall");
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 6'(10 + i), 32'(32'h100 + i), 1'b0, '0, '0, 1'b1);
         cycle();
      end
      applyStimulus(1'b1, 6'd20, 32'h200, 1'b0, '0, '0, 1'b1);
      cycle();
      cycle();
      applyStimulus(1'b1, 6'd20, 32'h200, 1'b0, '0, '0, 1'b0);
      cycle();
      cycle();
      drain("drain_full");

      $display("[TB] bypass lookup");
      applyStimulus(1'b1, 6'd7, 32'h11, 1'b0, '0, '0, 1'b1);
      cycle();
      applyStimulus(1'b0, '0, '0, 1'b1, 6'd7, 32'h22, 1'b1);
      cycle();
      idle(1'b1);
      rs_addr_i = 6'd7;
      cycle();
      rs_addr_i = 6'd8;
      cycle();
      rs_addr_i = 6'd7;
      drain("drain_byp");
      rs_addr_i = '0;

      $display("[TB] reset mid-operation");
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 6'(30 + i), 32'(32'h300 + i), 1'b0, '0, '0, 1'b1);
         cycle();
      end
      idle(1'b0);
      reset_i = 1'b1;
      applyStimulus(1'b1, 6'd33, 32'h333, 1'b0, '0, '0, 1'b0);
      cycle();
      reset_i = 1'b0;
      idle(1'b0);
      cycle();
      cycle();
      applyStimulus(1'b1, 6'd9, 32'h9999, 1'b0, '0, '0, 1'b0);
      cycle();
      idle(1'b0);
      cycle();
      cycle();

      $display("[TB] back-to-back pushes");
      trackMax = 1'b1;
      maxCnt   = 0;
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b1, 6'(40 + i), 32'(32'hC000 + i), 1'b0, '0, '0, 1'b0);
         cycle();
      end
      idle(1'b0);
      cycle();
      cycle();
      trackMax = 1'b0;
      checkVal("max_count", 32'(maxCnt), 32'd1);
      drain("drain_final");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
